// File: rtl/intra_net_requant.sv
// Requantizes one row of signed accumulators to int8 per beat (round, shift, ReLU, saturate)
// and tracks per-job row counts, done, saturation and overrun statistics.
module intra_net_requant #(
  parameter int COL_DIM    = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ACT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [4:0]                     cfg_shift,
  input  logic                           cfg_relu,
  input  logic [ROW_WIDTH-1:0]           cfg_rows,
  input  logic                           in_valid,
  input  logic [COL_DIM*ACC_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  output logic [COL_DIM-1:0]             out_w_en,
  output logic                           out_valid,
  output logic [COL_DIM*ACT_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    sat_count,
  output logic                           overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam int CNT_W = $clog2(COL_DIM + 1);
  localparam logic signed [ACC_WIDTH:0] Q_MAX   = {{(ACC_WIDTH+2-ACT_WIDTH){1'b0}}, {(ACT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] Q_MIN   = {{(ACC_WIDTH+2-ACT_WIDTH){1'b1}}, {(ACT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] RND_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROW_WIDTH-1:0]      ROW_ONE = {{(ROW_WIDTH-1){1'b0}}, 1'b1};

  state_t                      state_r;
  logic [4:0]                  shift_r;
  logic                        relu_r;
  logic [ROW_WIDTH-1:0]        rows_r;
  logic [ROW_WIDTH-1:0]        in_cnt_r;
  logic [ROW_WIDTH-1:0]        out_cnt_r;
  logic                        s1_valid_r;
  logic [ADDR_WIDTH-1:0]       s1_addr_r;
  logic signed [ACC_WIDTH:0]   s1_acc_r [COL_DIM];
  logic signed [ACC_WIDTH:0]   rnd_s;
  logic                        accept_s;
  logic [ACT_WIDTH:0]          lane_s;
  logic [COL_DIM*ACT_WIDTH-1:0] q_data_s;
  logic [CNT_W-1:0]            sat_n_s;
  logic [16:0]                 sat_sum_s;

  // Returns {clipped, value}; ReLU zeroing happens before the clip so it never counts as saturation.
  function automatic logic [ACT_WIDTH:0] requant_lane(input logic signed [ACC_WIDTH:0] r,
                                                      input logic [4:0] sh, input logic relu);
    logic signed [ACC_WIDTH:0] q;
    q = r >>> sh;
    q = (relu && q[ACC_WIDTH]) ? '0 : q;
    if (q > Q_MAX) requant_lane = {1'b1, Q_MAX[ACT_WIDTH-1:0]};
    else if (q < Q_MIN) requant_lane = {1'b1, Q_MIN[ACT_WIDTH-1:0]};
    else requant_lane = {1'b0, q[ACT_WIDTH-1:0]};
  endfunction

  assign accept_s  = (state_r == RUN) && in_valid;
  assign busy      = (state_r != IDLE);
  assign sat_sum_s = {1'b0, sat_count} + {{(17-CNT_W){1'b0}}, sat_n_s};

  // Half-LSB rounding offset for the configured shift.
  always_comb begin
    rnd_s = '0;
    if (shift_r == 5'd0) rnd_s = '0;
    else rnd_s = RND_ONE << (shift_r - 5'd1);
  end

  // Stage-2 combinational requantization of every lane plus the clipped-lane count.
  always_comb begin
    q_data_s = '0;
    sat_n_s  = '0;
    lane_s   = '0;
    for (int i = 0; i < COL_DIM; i++) begin
      lane_s = requant_lane(s1_acc_r[i], shift_r, relu_r);
      q_data_s[i*ACT_WIDTH +: ACT_WIDTH] = lane_s[ACT_WIDTH-1:0];
      sat_n_s = sat_n_s + {{(CNT_W-1){1'b0}}, lane_s[ACT_WIDTH]};
    end
  end

  // Stage-1 data: 33-bit sign-extended accumulator plus rounding offset (cannot overflow).
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < COL_DIM; i++) begin
        s1_acc_r[i] <= $signed({in_data[i*ACC_WIDTH+ACC_WIDTH-1], in_data[i*ACC_WIDTH +: ACC_WIDTH]}) + rnd_s;
      end
    end
  end

  // Job FSM, pipeline valids, registered outputs and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= 5'd0;
      relu_r     <= 1'b0;
      rows_r     <= '0;
      in_cnt_r   <= '0;
      out_cnt_r  <= '0;
      s1_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      out_valid  <= 1'b0;
      out_w_en   <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      done       <= 1'b0;
      sat_count  <= 16'd0;
      overrun    <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) s1_addr_r <= in_addr;
      out_valid <= s1_valid_r;
      out_w_en  <= {COL_DIM{s1_valid_r}};
      done      <= 1'b0;
      if (s1_valid_r) begin
        out_data  <= q_data_s;
        out_addr  <= s1_addr_r;
        out_cnt_r <= out_cnt_r + ROW_ONE;
        sat_count <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        if ((state_r == DRAIN) && (out_cnt_r + ROW_ONE == rows_r)) done <= 1'b1;
      end
      if (in_valid && (state_r != RUN)) overrun <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r   <= cfg_shift;
            relu_r    <= cfg_relu;
            rows_r    <= cfg_rows;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
            sat_count <= 16'd0;
            overrun   <= 1'b0;
            if (cfg_rows == '0) done <= 1'b1;
            else state_r <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            in_cnt_r <= in_cnt_r + ROW_ONE;
            if (in_cnt_r + ROW_ONE == rows_r) state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_net_requant.sv
// Scoreboard bench for intra_net_requant: stimulus pushes expected rows, a negedge monitor pops them.
module tb_intra_net_requant;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    cfg_shift = 5'd0;
  logic          cfg_relu = 1'b0;
  logic [7:0]    cfg_rows = 8'd0;
  logic          in_valid = 1'b0;
  logic [511:0]  in_data = '0;
  logic [9:0]    in_addr = 10'd0;
  logic [15:0]   out_w_en;
  logic          out_valid;
  logic [127:0]  out_data;
  logic [9:0]    out_addr;
  logic          busy;
  logic          done;
  logic [15:0]   sat_count;
  logic          overrun;

  typedef struct {
    logic [127:0] data;
    logic [9:0]   addr;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        lone_done = 1'b0;
  logic [31:0] acc_v [16];
  logic [7:0]  exp_v [16];

  intra_net_requant dut (
    .clk(clk), .reset(reset), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .cfg_rows(cfg_rows), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .out_w_en(out_w_en), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .sat_count(sat_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vecs();
    for (int i = 0; i < 16; i++) begin
      acc_v[i] = 32'd0;
      exp_v[i] = 8'd0;
    end
  endtask

  task automatic start_job(input logic [4:0] sh, input logic relu, input logic [7:0] rows);
    cfg_shift = sh;
    cfg_relu  = relu;
    cfg_rows  = rows;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Drives one beat for the coming edge and records the expected row two cycles later.
  task automatic drive_beat(input logic [9:0] addr, input logic last, input logic record);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      in_data[i*32 +: 32] = acc_v[i];
      e.data[i*8 +: 8]    = exp_v[i];
    end
    in_addr  = addr;
    in_valid = 1'b1;
    e.addr   = addr;
    e.last   = last;
    e.cyc    = cyc + 2;
    if (record) sb.push_back(e);
  endtask

  // Monitor: every output beat must match the head of the scoreboard at the right cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got addr %h data %h expected no output", out_addr, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_addr", {118'd0, out_addr}, {118'd0, e.addr});
          check("out_w_en", {112'd0, out_w_en}, {112'd0, 16'hFFFF});
          check("out_cycle", 128'(cyc), 128'(e.cyc));
          check("done_with_out", {127'd0, done}, {127'd0, e.last});
        end
      end else begin
        check("done_idle", {127'd0, done}, {127'd0, lone_done});
      end
    end
  end

  initial begin
    // reset state
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_misc", {93'd0, done, sat_count, overrun, out_w_en}, 128'd0);
    check("rst_data", out_data, 128'd0);
    tick();
    reset = 1'b0;
    tick();

    // shift=0 saturation, then an extra beat in DRAIN
    clear_vecs();
    acc_v[0] = 32'd5;          exp_v[0] = 8'd5;
    acc_v[1] = 32'd300;        exp_v[1] = 8'h7F;
    acc_v[2] = -32'sd300;      exp_v[2] = 8'h80;
    acc_v[3] = 32'd127;        exp_v[3] = 8'h7F;
    acc_v[4] = -32'sd128;      exp_v[4] = 8'h80;
    start_job(5'd0, 1'b0, 8'd1);
    check("busy_run", {127'd0, busy}, 128'd1);
    drive_beat(10'h001, 1'b1, 1'b1);
    tick();
    drive_beat(10'h002, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("overrun_drain", {127'd0, overrun}, 128'd1);
    tick();
    check("sat_count_t1", {112'd0, sat_count}, 128'd2);
    tick();
    tick();

    // shift=4 rounding and max accumulator
    clear_vecs();
    acc_v[0] = 32'd24;         exp_v[0] = 8'd2;
    acc_v[1] = -32'sd24;       exp_v[1] = 8'hFF;
    acc_v[2] = 32'd8;          exp_v[2] = 8'd1;
    acc_v[3] = -32'sd9;        exp_v[3] = 8'hFF;
    acc_v[4] = 32'h7FFFFFFF;   exp_v[4] = 8'h7F;
    start_job(5'd4, 1'b0, 8'd1);
    check("overrun_cleared", {127'd0, overrun}, 128'd0);
    drive_beat(10'h020, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_count_t2", {112'd0, sat_count}, 128'd1);
    tick();

    // ReLU
    clear_vecs();
    acc_v[0] = -32'sd5;        exp_v[0] = 8'd0;
    acc_v[1] = -32'sd300;      exp_v[1] = 8'd0;
    acc_v[2] = 32'd200;        exp_v[2] = 8'h7F;
    start_job(5'd0, 1'b1, 8'd1);
    drive_beat(10'h030, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_count_t3", {112'd0, sat_count}, 128'd1);
    tick();

    // three rows with a gap: beats at cycles 0,1,4
    start_job(5'd0, 1'b0, 8'd3);
    clear_vecs();
    acc_v[0] = 32'd1; exp_v[0] = 8'd1;
    drive_beat(10'h010, 1'b0, 1'b1);
    tick();
    acc_v[0] = 32'd2; exp_v[0] = 8'd2;
    drive_beat(10'h011, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    acc_v[0] = 32'd3; exp_v[0] = 8'd3;
    drive_beat(10'h012, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    check("busy_c5", {127'd0, busy}, 128'd1);
    tick();
    check("done_c6", {127'd0, done}, 128'd1);
    check("busy_c6", {127'd0, busy}, 128'd1);
    tick();
    check("busy_c7", {127'd0, busy}, 128'd0);
    check("done_c7", {127'd0, done}, 128'd0);
    tick();

    // rows=0: lone done, never busy
    cfg_rows = 8'd0;
    start    = 1'b1;
    tick();
    lone_done = 1'b1;
    start     = 1'b0;
    check("busy_rows0", {127'd0, busy}, 128'd0);
    tick();
    lone_done = 1'b0;
    check("busy_rows0_after", {127'd0, busy}, 128'd0);
    tick();

    // reset mid-RUN flushes the pipeline
    clear_vecs();
    acc_v[0] = 32'd9;
    start_job(5'd0, 1'b0, 8'd3);
    drive_beat(10'h040, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_outs", {93'd0, out_valid, done, sat_count, overrun, out_w_en}, 128'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_no_out", {127'd0, out_valid}, 128'd0);
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
